bcd2bin: RTL and testbench

Sequential 3-digit BCD-to-binary converter using reverse double-dabble: one shift-right-and-correct iteration per clock. It is the inverse of the existing binary-to-BCD display path. It converts operator/keypad digit entry (hundreds/tens/ones) back into a 10-bit binary value for the datapath. A start/busy/done handshake lets it sit between a digit-entry controller and any register-load consumer.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 19 +
 rtl/bcd2bin.sv | 122 ++++++++++++
 tb/tb_bcd2bin.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the BCD-to-binary converter.
package bcd_pkg;

    // Three keypad digits (hundreds/tens/ones) decode into a 10-bit value.
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int ITER   = 10;
    localparam int DIG_W  = 4;

    // Shift register holds all digit fields followed by the binary accumulator.
    localparam int SR_W   = DIGITS * DIG_W + BIN_W;

    // Iteration counter must be able to reach ITER.
    localparam int CNT_W  = $clog2(ITER + 1);

    // Largest legal BCD digit; anything above marks the request invalid.
    localparam logic [DIG_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when a 4-bit field is a legal BCD digit.
    function automatic logic digit_ok(input logic [DIG_W-1:0] d);
        return (d <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Decode-direction correction cell: a digit field that reads 8 or more after a
// right shift has borrowed a weight-10 bit from the digit above, so 3 is removed
// to restore a valid BCD value (inverse of the add-3 cell used for encoding).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    // Subtract 3 only for values >= 8, so the field can never underflow.
    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin.sv
// Sequential 3-digit BCD-to-binary converter (reverse double-dabble).
// One shift-right-and-correct iteration per clock; a start/busy/done handshake
// sits between the digit-entry controller and the consumer of the binary value.
module bcd2bin
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIG_W-1:0] hundreds,
    input  logic [DIG_W-1:0] tens,
    input  logic [DIG_W-1:0] ones,
    output logic [BIN_W-1:0] number,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_shift;
    logic [SR_W-1:0]    sr_next;

    logic               digits_ok;
    logic               load;
    logic               reject;
    logic               finish;

    // Request validity is judged on the live inputs; they only matter in IDLE.
    assign digits_ok = digit_ok(hundreds) && digit_ok(tens) && digit_ok(ones);

    // Logical right shift moves the lowest digit bit into the accumulator MSB.
    assign sr_shift = sr >> 1;

    // Binary accumulator passes through untouched; only digit fields are corrected.
    assign sr_next[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    // One correction cell per digit field, each acting independently.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_shift[BIN_W + g*DIG_W +: DIG_W]),
            .dout (sr_next [BIN_W + g*DIG_W +: DIG_W])
        );
    end

    // Busy is a direct decode of the registered state, so it is glitch-free.
    assign busy = (state == SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        reject    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (digits_ok) begin
                        load      = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        reject    = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // start is deliberately ignored here: no queueing, no restart.
                if (cnt == CNT_W'(ITER - 1)) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Shift register and iteration counter: load at accept, iterate in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= {hundreds, tens, ones, {BIN_W{1'b0}}};
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= sr_next;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result registers: number updates only on a completed conversion, err on any done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= finish | reject;
            if (finish) begin
                number <= sr_next[BIN_W-1:0];
                err    <= 1'b0;
            end else if (reject) begin
                err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: expected results are queued when a request is
// driven and compared when the DUT raises done.
module tb_bcd2bin;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] hundreds = '0;
    logic [3:0] tens = '0;
    logic [3:0] ones = '0;
    logic [9:0] number;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        logic [9:0] num;
        logic       e;
        int         busy_cyc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       sb_e;
    logic [9:0] last_num = '0;
    int         busy_run = 0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    bcd2bin dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .number   (number),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used for done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive a request at the current negedge; sampled at the next posedge.
    task automatic request(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        exp_t x;
        hundreds = h;
        tens     = t;
        ones     = o;
        start    = 1'b1;
        if (h <= 9 && t <= 9 && o <= 9) begin
            x.num      = 10'(int'(h) * 100 + int'(t) * 10 + int'(o));
            x.e        = 1'b0;
            x.busy_cyc = 10;
            last_num   = x.num;
        end else begin
            x.num      = last_num;
            x.e        = 1'b1;
            x.busy_cyc = 0;
        end
        sb_q.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) return;
            @(negedge clk);
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: count busy cycles and score each done pulse against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("number", 32'(number), 32'(sb_e.num));
                    check("err", 32'(err), 32'(sb_e.e));
                    check("busy_cycles", 32'(busy_run), 32'(sb_e.busy_cyc));
                end
                busy_run = 0;
            end
        end
    end

    initial begin : stim
        int d1;
        int d2;

        // Reset and idle behaviour.
        #12;
        check("rst_number", 32'(number), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(15);
        check("idle_number", 32'(number), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_err", 32'(err), 32'd0);

        // Directed conversions including both extremes.
        request(4'd9, 4'd9, 4'd9); wait_done(20); idle_cycles(2);
        request(4'd0, 4'd0, 4'd0); wait_done(20); idle_cycles(2);
        request(4'd2, 4'd5, 4'd5); wait_done(20); idle_cycles(2);
        request(4'd1, 4'd2, 4'd8); wait_done(20); idle_cycles(2);

        // Invalid tens digit: immediate error, number keeps 0x080.
        request(4'd1, 4'hA, 4'd3); wait_done(5);
        idle_cycles(3);
        check("err_hold", 32'(err), 32'd1);
        check("err_done_low", 32'(done), 32'd0);
        check("err_number_hold", 32'(number), 32'h080);

        // Invalid hundreds and ones digits too.
        request(4'hF, 4'd0, 4'd0); wait_done(5); idle_cycles(2);
        request(4'd3, 4'd3, 4'hB); wait_done(5); idle_cycles(2);

        // start during busy with new digits is ignored.
        request(4'd4, 4'd5, 4'd6);
        idle_cycles(2);
        hundreds = 4'd1; tens = 4'd1; ones = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        idle_cycles(15);

        // Back-to-back: second start in the done cycle.
        request(4'd0, 4'd0, 4'd1);
        wait_done(20);
        d1 = cyc;
        request(4'd3, 4'd0, 4'd0);
        wait_done(20);
        d2 = cyc;
        check("b2b_spacing", 32'(d2 - d1), 32'd11);
        idle_cycles(3);

        // Random legal digits.
        for (int i = 0; i < 6; i++) begin
            request(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
            wait_done(20);
            idle_cycles(1);
        end

        // Reset mid-conversion abandons the request.
        request(4'd7, 4'd7, 4'd7);
        idle_cycles(3);
        rst_n = 1'b0;
        sb_q.delete();
        last_num = '0;
        #1;
        check("abort_number", 32'(number), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(15);
        check("post_abort_number", 32'(number), 32'd0);
        request(4'd7, 4'd7, 4'd7); wait_done(20);
        idle_cycles(3);
        check("final_number", 32'(number), 32'h309);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
